// File: rtl/calc1_pkg.sv
// calc1_pkg: shared command/response encodings and types for the calc1 port arbiter.
package calc1_pkg;
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;
    localparam logic [1:0] RSP_NONE = 2'd0;
    localparam logic [1:0] RSP_OK   = 2'd1;
    localparam logic [1:0] RSP_ERR  = 2'd2;
    typedef enum logic [1:0] {ST_IDLE, ST_OP2, ST_PEND, ST_WAIT} port_state_e;
    typedef logic [1:0] tag_t;
    function automatic logic cmd_uses_alu(input logic [3:0] c);
        return c == CMD_ADD || c == CMD_SUB || c == CMD_SHL || c == CMD_SHR;
    endfunction
endpackage

// File: rtl/calc1_port_ctl.sv
// calc1_port_ctl: one port's two-cycle command capture FSM and one-cycle response register.
module calc1_port_ctl
    import calc1_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    cmd_i,
    input  logic [DW-1:0] data_i,
    input  logic          accept_i,
    input  logic          rsp_hit_i,
    input  logic [1:0]    rsp_code_i,
    input  logic [DW-1:0] rsp_data_i,
    output logic          pend_d_o,
    output logic          wait_o,
    output logic [3:0]    cmd_o,
    output logic [DW-1:0] op1_o,
    output logic [DW-1:0] op2_o,
    output logic [1:0]    resp_o,
    output logic [DW-1:0] data_o
);
    port_state_e   state_q, state_d;
    logic [3:0]    cmd_q;
    logic [DW-1:0] op1_q, op2_q, data_q, data_d;
    logic [1:0]    resp_q, resp_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = (cmd_i != '0) ? ST_OP2 : ST_IDLE;
            ST_OP2:  state_d = cmd_uses_alu(cmd_q) ? ST_PEND : ST_IDLE;
            ST_PEND: state_d = accept_i ? ST_WAIT : ST_PEND;
            ST_WAIT: state_d = rsp_hit_i ? ST_IDLE : ST_WAIT;
            default: state_d = ST_IDLE;
        endcase
    end

    // Unsupported commands answer locally right after op2 without touching the ALU.
    always_comb begin
        pend_d_o = state_d == ST_PEND;
        wait_o   = state_q == ST_WAIT;
        resp_d   = (state_q == ST_OP2 && !cmd_uses_alu(cmd_q)) ? RSP_ERR :
                   (state_q == ST_WAIT && rsp_hit_i) ? rsp_code_i : RSP_NONE;
        data_d   = (state_q == ST_WAIT && rsp_hit_i) ? rsp_data_i : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q  <= '0;
            op1_q  <= '0;
            op2_q  <= '0;
            resp_q <= RSP_NONE;
            data_q <= '0;
        end else begin
            if (state_q == ST_IDLE && cmd_i != '0) begin
                cmd_q <= cmd_i;
                op1_q <= data_i;
            end
            if (state_q == ST_OP2) op2_q <= data_i;
            resp_q <= resp_d;
            data_q <= data_d;
        end
    end

    assign cmd_o  = cmd_q;
    assign op1_o  = op1_q;
    assign op2_o  = op2_q;
    assign resp_o = resp_q;
    assign data_o = data_q;
endmodule

// File: rtl/calc1_port_arbiter.sv
// calc1_port_arbiter: four-port capture front end, round-robin ALU issue and tagged response demux.
module calc1_port_arbiter
    import calc1_pkg::*;
#(
    parameter int NPORTS = 4,
    parameter int DW     = 32
) (
    input  logic          c_clk,
    input  logic          reset,
    input  logic [0:3]    req1_cmd_in,
    input  logic [0:DW-1] req1_data_in,
    input  logic [0:3]    req2_cmd_in,
    input  logic [0:DW-1] req2_data_in,
    input  logic [0:3]    req3_cmd_in,
    input  logic [0:DW-1] req3_data_in,
    input  logic [0:3]    req4_cmd_in,
    input  logic [0:DW-1] req4_data_in,
    output logic [0:1]    out_resp1,
    output logic [0:DW-1] out_data1,
    output logic [0:1]    out_resp2,
    output logic [0:DW-1] out_data2,
    output logic [0:1]    out_resp3,
    output logic [0:DW-1] out_data3,
    output logic [0:1]    out_resp4,
    output logic [0:DW-1] out_data4,
    output logic          alu_req_valid,
    input  logic          alu_req_ready,
    output logic [0:3]    alu_cmd,
    output logic [0:DW-1] alu_op1,
    output logic [0:DW-1] alu_op2,
    output logic [0:1]    alu_tag,
    input  logic          alu_rsp_valid,
    input  logic [0:1]    alu_rsp_tag,
    input  logic [0:1]    alu_rsp_code,
    input  logic [0:DW-1] alu_rsp_data,
    output logic          err_unexp_rsp
);
    logic [3:0]        cmd_a  [NPORTS];
    logic [DW-1:0]     din_a  [NPORTS];
    logic [3:0]        pcmd_a [NPORTS];
    logic [DW-1:0]     op1_a  [NPORTS];
    logic [DW-1:0]     op2_a  [NPORTS];
    logic [DW-1:0]     dout_a [NPORTS];
    logic [1:0]        resp_a [NPORTS];
    logic [NPORTS-1:0] pend_d, waiting, accept, rsp_hit;
    logic              valid_q, valid_d, err_q, err_d, xfer, found;
    tag_t              tag_q, tag_d, ptr_q, ptr_d, sel, idx;

    assign cmd_a[0] = req1_cmd_in;
    assign cmd_a[1] = req2_cmd_in;
    assign cmd_a[2] = req3_cmd_in;
    assign cmd_a[3] = req4_cmd_in;
    assign din_a[0] = req1_data_in;
    assign din_a[1] = req2_data_in;
    assign din_a[2] = req3_data_in;
    assign din_a[3] = req4_data_in;

    for (genvar i = 0; i < NPORTS; i++) begin : g_port
        assign accept[i]  = xfer && tag_q == tag_t'(i);
        assign rsp_hit[i] = alu_rsp_valid && alu_rsp_tag == tag_t'(i);
        calc1_port_ctl #(.DW(DW)) u_port (
            .clk        (c_clk),
            .rst_n      (reset),
            .cmd_i      (cmd_a[i]),
            .data_i     (din_a[i]),
            .accept_i   (accept[i]),
            .rsp_hit_i  (rsp_hit[i]),
            .rsp_code_i (alu_rsp_code),
            .rsp_data_i (alu_rsp_data),
            .pend_d_o   (pend_d[i]),
            .wait_o     (waiting[i]),
            .cmd_o      (pcmd_a[i]),
            .op1_o      (op1_a[i]),
            .op2_o      (op2_a[i]),
            .resp_o     (resp_a[i]),
            .data_o     (dout_a[i])
        );
    end

    // Arbitrate on next-cycle PEND status so valid rises in the first PEND cycle.
    always_comb begin
        xfer  = valid_q && alu_req_ready;
        ptr_d = xfer ? tag_q + tag_t'(1) : ptr_q;
        found = 1'b0;
        sel   = ptr_d;
        idx   = '0;
        for (int k = 0; k < NPORTS; k++) begin
            idx = ptr_d + tag_t'(k);
            if (!found && pend_d[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
        valid_d = (valid_q && !alu_req_ready) ? 1'b1 : found;
        tag_d   = (valid_q && !alu_req_ready) ? tag_q : sel;
        err_d   = err_q || (alu_rsp_valid && !waiting[alu_rsp_tag]);
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            ptr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
        end
    end

    assign alu_req_valid = valid_q;
    assign alu_tag       = valid_q ? tag_q : '0;
    assign alu_cmd       = valid_q ? pcmd_a[tag_q] : '0;
    assign alu_op1       = valid_q ? op1_a[tag_q] : '0;
    assign alu_op2       = valid_q ? op2_a[tag_q] : '0;
    assign err_unexp_rsp = err_q;
    assign out_resp1     = resp_a[0];
    assign out_resp2     = resp_a[1];
    assign out_resp3     = resp_a[2];
    assign out_resp4     = resp_a[3];
    assign out_data1     = dout_a[0];
    assign out_data2     = dout_a[1];
    assign out_data3     = dout_a[2];
    assign out_data4     = dout_a[3];
endmodule
